// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_read_mode_e;

    function automatic int fifo_level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Keeps pointers at least one bit wide even for degenerate moduli.
    function automatic int fifo_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_mod_counter.sv
// Modulo-N up-counter with explicit wrap, used for the FIFO read and write pointers.
module fifo_mod_counter
    import fifo_pkg::*;
#(
    parameter  int MODULUS = 8,
    localparam int W       = fifo_ptr_width(MODULUS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Wrap is explicit so non-power-of-two moduli never reach unused slots.
    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (inc) begin
            value_d = (value_q == LAST) ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Synchronous FIFO with arbitrary depth, standard or fall-through read,
// programmable almost-full/almost-empty thresholds and synchronous flush.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter  int              DATA_WIDTH  = 16,
    parameter  int              DEPTH       = 8,
    parameter  fifo_read_mode_e READ_MODE   = FIFO_STD,
    localparam int              LEVEL_WIDTH = fifo_level_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   write_enable,
    input  logic [DATA_WIDTH-1:0]  data_input,
    input  logic                   read_enable,
    output logic [DATA_WIDTH-1:0]  data_output,
    output logic                   read_valid,
    output logic                   write_acknowledge,
    output logic                   overflow_flag,
    output logic                   underflow_flag,
    input  logic [LEVEL_WIDTH-1:0] almost_full_threshold,
    input  logic [LEVEL_WIDTH-1:0] almost_empty_threshold,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   full_flag,
    output logic                   empty_flag,
    output logic                   almost_full_flag,
    output logic                   almost_empty_flag
);

    localparam int                     PTR_W   = fifo_ptr_width(DEPTH);
    localparam logic [LEVEL_WIDTH-1:0] DEPTH_L = LEVEL_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]       wptr;
    logic [PTR_W-1:0]       rptr;
    logic [LEVEL_WIDTH-1:0] level_q;
    logic [LEVEL_WIDTH-1:0] level_d;
    logic                   wr_acc;
    logic                   rd_acc;
    logic                   wr_rej;
    logic                   rd_rej;
    logic                   ack_q;
    logic                   ovf_q;
    logic                   udf_q;
    logic [DATA_WIDTH-1:0]  head;

    // A full FIFO still takes a write when a read frees a slot in the same cycle;
    // an empty FIFO never forwards a same-cycle write to the reader.
    always_comb begin
        rd_acc = !flush && read_enable && (level_q != '0);
        wr_acc = !flush && write_enable && ((level_q != DEPTH_L) || rd_acc);
        wr_rej = !flush && write_enable && !wr_acc;
        rd_rej = !flush && read_enable && (level_q == '0);
    end

    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    fifo_mod_counter #(.MODULUS(DEPTH)) u_wptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (wr_acc),
        .value (wptr)
    );

    fifo_mod_counter #(.MODULUS(DEPTH)) u_rptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (rd_acc),
        .value (rptr)
    );

    // Storage carries no reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (wr_acc && !reset) begin
            mem_q[wptr] <= data_input;
        end
    end

    assign head = mem_q[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            ack_q   <= wr_acc;
            ovf_q   <= wr_rej;
            udf_q   <= rd_rej;
        end
    end

    generate
        if (READ_MODE == FIFO_STD) begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic [DATA_WIDTH-1:0] dout_d;
            logic                  rvalid_q;

            always_comb begin
                dout_d = rd_acc ? head : dout_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_q   <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    dout_q   <= dout_d;
                    rvalid_q <= rd_acc;
                end
            end

            assign data_output = dout_q;
            assign read_valid  = rvalid_q;
        end else begin : g_fwft
            logic [DATA_WIDTH-1:0] dout_q;
            logic [DATA_WIDTH-1:0] dout_d;

            // While empty the last presented word is held, so flush keeps the
            // output stable and reset forces it to zero.
            always_comb begin
                dout_d = (level_q != '0) ? head : dout_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign data_output = dout_d;
            assign read_valid  = (level_q != '0);
        end
    endgenerate

    assign level             = level_q;
    assign write_acknowledge = ack_q;
    assign overflow_flag     = ovf_q;
    assign underflow_flag    = udf_q;
    assign full_flag         = (level_q == DEPTH_L);
    assign empty_flag        = (level_q == '0);
    assign almost_full_flag  = (level_q >= almost_full_threshold);
    assign almost_empty_flag = (level_q <= almost_empty_threshold);

`ifdef ENABLE_ASSERTIONS
    a_level_bound: assert property (@(posedge clk) disable iff (reset)
        level_q <= DEPTH_L);

    a_flag_consistency: assert property (@(posedge clk) disable iff (reset)
        !(full_flag && empty_flag) && (empty_flag == (level_q == '0))
        && (full_flag == (level_q == DEPTH_L)));

    a_ack_ovf_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(write_acknowledge && overflow_flag));
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed scoreboard bench for fifo_sync_param: one standard-read and one fall-through instance.
module tb_fifo_sync_param;
    import fifo_pkg::*;

    localparam int DW = 16;
    localparam int D  = 6;
    localparam int LW = fifo_level_width(D);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [LW-1:0] af_thr, ae_thr;

    logic          s_flush, s_we, s_re;
    logic [DW-1:0] s_din, s_dout;
    logic          s_rv, s_ack, s_ovf, s_udf, s_full, s_empty, s_af, s_ae;
    logic [LW-1:0] s_level;

    logic          f_flush, f_we, f_re;
    logic [DW-1:0] f_din, f_dout;
    logic          f_rv, f_ack, f_ovf, f_udf, f_full, f_empty, f_af, f_ae;
    logic [LW-1:0] f_level;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] s_exp_q[$];
    logic [DW-1:0] f_exp_q[$];

    fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(D), .READ_MODE(FIFO_STD)) u_std (
        .clk                    (clk),
        .reset                  (reset),
        .flush                  (s_flush),
        .write_enable           (s_we),
        .data_input             (s_din),
        .read_enable            (s_re),
        .data_output            (s_dout),
        .read_valid             (s_rv),
        .write_acknowledge      (s_ack),
        .overflow_flag          (s_ovf),
        .underflow_flag         (s_udf),
        .almost_full_threshold  (af_thr),
        .almost_empty_threshold (ae_thr),
        .level                  (s_level),
        .full_flag              (s_full),
        .empty_flag             (s_empty),
        .almost_full_flag       (s_af),
        .almost_empty_flag      (s_ae)
    );

    fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(D), .READ_MODE(FIFO_FWFT)) u_fwft (
        .clk                    (clk),
        .reset                  (reset),
        .flush                  (f_flush),
        .write_enable           (f_we),
        .data_input             (f_din),
        .read_enable            (f_re),
        .data_output            (f_dout),
        .read_valid             (f_rv),
        .write_acknowledge      (f_ack),
        .overflow_flag          (f_ovf),
        .underflow_flag         (f_udf),
        .almost_full_threshold  (af_thr),
        .almost_empty_threshold (ae_thr),
        .level                  (f_level),
        .full_flag              (f_full),
        .empty_flag             (f_empty),
        .almost_full_flag       (f_af),
        .almost_empty_flag      (f_ae)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_we = 1'b0; s_re = 1'b0; s_flush = 1'b0;
        f_we = 1'b0; f_re = 1'b0; f_flush = 1'b0;
    endtask

    // Monitor: pops the expected word whenever a read is presented.
    always @(negedge clk) begin
        if (!reset) begin
            if (s_rv) begin
                if (s_exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL std_unexpected_read: got 0x%0h, expected no read_valid", s_dout);
                end else begin
                    chk("std_read_data", int'(s_dout), int'(s_exp_q.pop_front()));
                end
            end
            if (f_rv && f_re) begin
                if (f_exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL fwft_unexpected_pop: got 0x%0h, expected no pop", f_dout);
                end else begin
                    chk("fwft_read_data", int'(f_dout), int'(f_exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] drain_exp [6];
        drain_exp = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h00AA};

        idle();
        s_din = '0; f_din = '0;
        af_thr = LW'(4); ae_thr = LW'(1);
        reset = 1'b1;
        step();
        step();
        chk("rst_level", s_level, 0);
        chk("rst_empty", s_empty, 1);
        chk("rst_rvalid", s_rv, 0);
        chk("rst_dout", s_dout, 0);
        chk("rst_ack", s_ack, 0);
        chk("rst_ovf", s_ovf, 0);
        chk("rst_udf", s_udf, 0);
        chk("rst_fwft_rvalid", f_rv, 0);
        chk("rst_fwft_dout", f_dout, 0);
        reset = 1'b0;
        chk("lvl0_almost_empty", s_ae, 1);
        chk("lvl0_almost_full", s_af, 0);

        // Fill to full, then overflow.
        for (int i = 1; i <= 6; i++) begin
            s_we = 1'b1; s_din = DW'(i);
            step();
            chk("fill_ack", s_ack, 1);
            chk("fill_level", s_level, i);
            chk("fill_full", s_full, (i == 6) ? 1 : 0);
            chk("fill_almost_full", s_af, (i >= 4) ? 1 : 0);
            chk("fill_almost_empty", s_ae, (i <= 1) ? 1 : 0);
        end
        s_din = 16'h0007;
        step();
        chk("ovf_flag", s_ovf, 1);
        chk("ovf_no_ack", s_ack, 0);
        chk("ovf_level", s_level, 6);

        // Full with simultaneous read: write is accepted into the wrapped slot.
        s_we = 1'b1; s_re = 1'b1; s_din = 16'h00AA;
        s_exp_q.push_back(16'h0001);
        step();
        chk("full_rw_ack", s_ack, 1);
        chk("full_rw_ovf", s_ovf, 0);
        chk("full_rw_level", s_level, 6);

        s_we = 1'b0; s_re = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s_exp_q.push_back(drain_exp[k]);
            step();
            chk("drain_level", s_level, 5 - k);
        end
        chk("drain_empty", s_empty, 1);

        // Read and write on empty: read rejected, write accepted.
        s_we = 1'b1; s_re = 1'b1; s_din = 16'h0055;
        step();
        chk("empty_rw_udf", s_udf, 1);
        chk("empty_rw_ack", s_ack, 1);
        chk("empty_rw_level", s_level, 1);
        s_we = 1'b0; s_re = 1'b1;
        s_exp_q.push_back(16'h0055);
        step();
        chk("empty_rw_drain_level", s_level, 0);
        idle();

        // Threshold above depth, then flush at level 3.
        af_thr = LW'(7);
        for (int i = 0; i < 3; i++) begin
            s_we = 1'b1; s_din = DW'(16'h0010 + i);
            step();
            chk("af7_almost_full", s_af, 0);
        end
        chk("pre_flush_level", s_level, 3);
        s_flush = 1'b1; s_we = 1'b1; s_din = 16'h0099;
        step();
        chk("flush_level", s_level, 0);
        chk("flush_empty", s_empty, 1);
        chk("flush_no_ack", s_ack, 0);
        chk("flush_no_ovf", s_ovf, 0);
        chk("flush_rvalid", s_rv, 0);
        chk("flush_dout_hold", s_dout, 16'h0055);
        s_flush = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            s_we = 1'b1; s_din = DW'(16'h0020 + i);
            step();
            chk("af7_fill_almost_full", s_af, 0);
        end
        chk("af7_full", s_full, 1);

        // Reset in the middle of a read/write burst.
        s_we = 1'b1; s_re = 1'b1; s_din = 16'h0066; reset = 1'b1;
        step();
        chk("midrst_level", s_level, 0);
        chk("midrst_dout", s_dout, 0);
        chk("midrst_rvalid", s_rv, 0);
        chk("midrst_ack", s_ack, 0);
        chk("midrst_ovf", s_ovf, 0);
        chk("midrst_udf", s_udf, 0);
        chk("midrst_empty", s_empty, 1);
        reset = 1'b0;
        s_we = 1'b1; s_re = 1'b0; s_din = 16'h0077;
        step();
        chk("post_rst_ack", s_ack, 1);
        s_we = 1'b0; s_re = 1'b1;
        s_exp_q.push_back(16'h0077);
        step();
        idle();
        af_thr = LW'(4);

        // Fall-through instance.
        f_we = 1'b1; f_din = 16'h1234;
        step();
        f_we = 1'b0;
        chk("fwft_dout", f_dout, 16'h1234);
        chk("fwft_rvalid", f_rv, 1);
        f_re = 1'b1;
        f_exp_q.push_back(16'h1234);
        step();
        chk("fwft_pop_rvalid", f_rv, 0);
        chk("fwft_pop_empty", f_empty, 1);
        f_re = 1'b0; f_we = 1'b1; f_din = 16'h00A1;
        step();
        f_din = 16'h00A2;
        step();
        f_we = 1'b0; f_re = 1'b1;
        f_exp_q.push_back(16'h00A1);
        step();
        chk("fwft_level1", f_level, 1);
        f_exp_q.push_back(16'h00A2);
        step();
        chk("fwft_level0", f_level, 0);
        step();
        chk("fwft_udf", f_udf, 1);
        idle();

        step();
        step();
        chk("std_queue_drained", s_exp_q.size(), 0);
        chk("fwft_queue_drained", f_exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
